pwm_capture: RTL and testbench

Measures an incoming PWM waveform: high time and period, in clk cycles. It is the receive-side counterpart of the team's PWM generator, for loopback self-test and for reading external PWM sensors. Results are published with a one-cycle valid strobe. A stuck-line timeout reports DC levels.

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_duty_div.sv | 74 +++++++
 rtl/pwm_capture.sv | 173 +++++++++++++++++
 tb/tb_pwm_capture.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the PWM capture block.
//   state_t   - capture FSM states (IDLE: no reference edge yet,
//               HIGH: inside the high phase, LOW: inside the low phase)
//   PCT_SCALE - duty is reported in percent
//   DUTY_W    - width of the duty result (0..100 fits in 7 bits)
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  localparam int PCT_SCALE = 100;
  localparam int DUTY_W    = 7;

endpackage

// File: rtl/pwm_duty_div.sv
// pwm_duty_div: restoring divider, one quotient bit per cycle.
// Only built when PWM_CAPTURE_DUTY_EN is defined.
//   clk, rst_n : clock, async active-low reset
//   start      : load dividend/divisor; ignored while busy
//   abort      : drop the running division, no done pulse
//   dividend   : CNT_W+DUTY_W bit numerator
//   divisor    : CNT_W bit denominator, must be non-zero
//   busy       : division in progress
//   done       : high during the final step; quotient is valid that cycle
//   quotient   : low DUTY_W bits of the result (the ratio never exceeds 100)
module pwm_duty_div
  import pwm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [CNT_W+DUTY_W-1:0] dividend,
  input  logic [CNT_W-1:0]        divisor,
  output logic                    busy,
  output logic                    done,
  output logic [DUTY_W-1:0]       quotient
);

  localparam int DVD_W  = CNT_W + DUTY_W;
  localparam int STEP_W = $clog2(DVD_W);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DVD_W - 1);

  logic [DVD_W-1:0]  dvd_q, dvd_next;
  logic [CNT_W-1:0]  rem_q, rem_next, dsr_q;
  logic [STEP_W-1:0] step_q;
  logic [CNT_W:0]    trial;
  logic              fits;

  // The dividend register doubles as the quotient register: each step shifts
  // one dividend bit into the remainder and one quotient bit in at the LSB.
  // NOTE: every signal here is assigned on every path, so no latch is inferred.
  always_comb begin
    trial    = {rem_q, dvd_q[DVD_W-1]};
    fits     = (trial >= {1'b0, dsr_q});
    rem_next = fits ? CNT_W'(trial - {1'b0, dsr_q}) : trial[CNT_W-1:0];
    dvd_next = {dvd_q[DVD_W-2:0], fits};
  end

  assign done     = busy & (step_q == LAST_STEP) & ~abort;
  assign quotient = dvd_next[DUTY_W-1:0];

  // NOTE: datapath registers are reset as well; it is cheap and keeps X out of the quotient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      dvd_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      step_q <= '0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start && !busy) begin
      busy   <= 1'b1;
      dvd_q  <= dividend;
      rem_q  <= '0;
      dsr_q  <= divisor;
      step_q <= '0;
    end else if (busy) begin
      dvd_q  <= dvd_next;
      rem_q  <= rem_next;
      step_q <= step_q + STEP_W'(1);
      if (step_q == LAST_STEP) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input,
// in clk cycles, and reports a stuck line after TIMEOUT cycles without edges.
// Optional duty-percent output is built when PWM_CAPTURE_DUTY_EN is defined.
//   clk, rst_n  : clock, async active-low reset
//   pwm_in      : asynchronous PWM input
//   high_time   : last measured high time (0 on a stuck report)
//   period      : last measured period (0 on a stuck report)
//   meas_valid  : one-cycle strobe when high_time/period/stuck update
//   stuck       : no edges for TIMEOUT cycles; level is on pwm_level
//   pwm_level   : synchronised pwm_in
//   duty_pct    : high_time*100/period, or 0/100 on a stuck line
//   duty_valid  : one-cycle strobe when duty_pct updates
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  high_time,
  output logic [CNT_W-1:0]  period,
  output logic              meas_valid,
  output logic              stuck,
  output logic              pwm_level,
  output logic [DUTY_W-1:0] duty_pct,
  output logic              duty_valid
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   level, rise, fall, timeout;
  state_t                 state;
  logic [CNT_W-1:0]       hcnt, pcnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      prev_q <= level;
    end
  end

  assign level     = sync_q[SYNC_STAGES-1];
  assign pwm_level = level;
  assign rise      = level & ~prev_q;
  assign fall      = ~level & prev_q;
  // pcnt has already counted TIMEOUT-1 cycles; this cycle would be the TIMEOUT-th.
  assign timeout   = (pcnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hcnt       <= '0;
      pcnt       <= '0;
      high_time  <= '0;
      period     <= '0;
      stuck      <= 1'b0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            hcnt  <= ONE;
            pcnt  <= ONE;
            state <= HIGH;
          end else if (timeout) begin
            high_time  <= '0;
            period     <= '0;
            stuck      <= 1'b1;
            meas_valid <= 1'b1;
            pcnt       <= '0;
          end else begin
            pcnt <= pcnt + ONE;
          end
        end
        HIGH: begin
          // Timeout is checked before the fall so pcnt can never pass TIMEOUT-1.
          if (timeout) begin
            high_time  <= '0;
            period     <= '0;
            stuck      <= 1'b1;
            meas_valid <= 1'b1;
            hcnt       <= '0;
            pcnt       <= '0;
            state      <= IDLE;
          end else if (fall) begin
            pcnt  <= pcnt + ONE;
            state <= LOW;
          end else begin
            hcnt <= hcnt + ONE;
            pcnt <= pcnt + ONE;
          end
        end
        LOW: begin
          if (rise) begin
            high_time  <= hcnt;
            period     <= pcnt;
            stuck      <= 1'b0;
            meas_valid <= 1'b1;
            hcnt       <= ONE;
            pcnt       <= ONE;
            state      <= HIGH;
          end else if (timeout) begin
            high_time  <= '0;
            period     <= '0;
            stuck      <= 1'b1;
            meas_valid <= 1'b1;
            hcnt       <= '0;
            pcnt       <= '0;
            state      <= IDLE;
          end else begin
            pcnt <= pcnt + ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PWM_CAPTURE_DUTY_EN
  logic                    div_start, div_abort, div_busy, div_done;
  logic [CNT_W+DUTY_W-1:0] div_dividend;
  logic [DUTY_W-1:0]       div_quot;

  assign div_start    = meas_valid & ~stuck & ~div_busy;
  assign div_abort    = meas_valid & stuck;
  assign div_dividend = (CNT_W+DUTY_W)'(high_time) * (CNT_W+DUTY_W)'(PCT_SCALE);

  pwm_duty_div #(
    .CNT_W (CNT_W)
  ) u_duty_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (div_dividend),
    .divisor  (period),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  // A stuck line has a trivially known duty; it also cancels any division.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_pct   <= '0;
      duty_valid <= 1'b0;
    end else if (div_abort) begin
      duty_pct   <= pwm_level ? DUTY_W'(PCT_SCALE) : '0;
      duty_valid <= 1'b1;
    end else if (div_done) begin
      duty_pct   <= div_quot;
      duty_valid <= 1'b1;
    end else begin
      duty_valid <= 1'b0;
    end
  end
`else
  assign duty_pct   = '0;
  assign duty_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized and directed stimulus for pwm_capture with a
// timestamp-based reference model and a queue scoreboard. Duty checks are
// active when PWM_CAPTURE_DUTY_EN is defined.
module tb_pwm_capture;

  localparam int CNT_W    = 32;
  localparam int TIMEOUT  = 1000;
  localparam int SS       = 2;
  localparam int CLK_HALF = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] high_time, period;
  logic             meas_valid, stuck, pwm_level;
  logic [6:0]       duty_pct;
  logic             duty_valid;

  pwm_capture #(
    .CNT_W       (CNT_W),
    .TIMEOUT     (TIMEOUT),
    .SYNC_STAGES (SS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .high_time  (high_time),
    .period     (period),
    .meas_valid (meas_valid),
    .stuck      (stuck),
    .pwm_level  (pwm_level),
    .duty_pct   (duty_pct),
    .duty_valid (duty_valid)
  );

  always #CLK_HALF clk = ~clk;

  typedef struct {
    int          t;
    logic [63:0] h;
    logic [63:0] p;
    bit          s;
    bit          lvl;
  } meas_t;

  typedef struct {
    int t;
    int v;
  } duty_t;

  meas_t exp_meas[$];
  duty_t exp_duty[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = -1;

  // Reference model state: times are in clk cycles since reset release.
  bit armed, prev_l, fell;
  int t_rise, t_fall, t_win;
  bit dly[$];
  bit pend;
  int pend_t, pend_v, div_free_at;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0d, want %0d", name, cyc, got, want);
  endtask

  task automatic model_reset();
    armed = 0; prev_l = 0; fell = 0;
    t_rise = 0; t_fall = 0; t_win = 0;
    pend = 0; pend_t = 0; pend_v = 0; div_free_at = 0;
    dly.delete();
    for (int i = 0; i <= SS; i++) dly.push_back(1'b0);
    exp_meas.delete();
    exp_duty.delete();
  endtask

  task automatic push_stuck(input int j);
    meas_t e;
    duty_t d;
    bit    vis_lvl;
    vis_lvl = dly[SS-1];  // synchroniser output shown on pwm_level that cycle
    e.t = j; e.h = 0; e.p = 0; e.s = 1; e.lvl = vis_lvl;
    exp_meas.push_back(e);
`ifdef PWM_CAPTURE_DUTY_EN
    if (pend && pend_t > j) pend = 0;
    d.t = j + 1; d.v = vis_lvl ? 100 : 0;
    exp_duty.push_back(d);
    div_free_at = j + 1;
`else
    d.t = 0; d.v = 0;
`endif
  endtask

  task automatic push_meas(input int j, input int h, input int p);
    meas_t e;
    e.t = j; e.h = h; e.p = p; e.s = 0; e.lvl = 0;
    exp_meas.push_back(e);
`ifdef PWM_CAPTURE_DUTY_EN
    if (j >= div_free_at) begin
      pend = 1; pend_t = j + CNT_W + 8; pend_v = (h * 100) / p;
      div_free_at = pend_t;
    end
`endif
  endtask

  // Model of one cycle: the edge seen at cycle j is the input driven SS+1 cycles earlier.
  task automatic model_step(input int j);
    bit    lv, rise, fall;
    duty_t d;
    lv = dly[SS];
    rise = lv & ~prev_l;
    fall = ~lv & prev_l;
    prev_l = lv;
    if (pend && pend_t == j) begin
      d.t = j; d.v = pend_v;
      exp_duty.push_back(d);
      pend = 0;
    end
    if (!armed) begin
      if (rise) begin
        armed = 1; t_rise = j; fell = 0;
      end else if (j - t_win >= TIMEOUT - 1) begin
        push_stuck(j); t_win = j + 1;
      end
    end else begin
      if (rise) begin
        push_meas(j, t_fall - t_rise, j - t_rise);
        t_rise = j; fell = 0;
      end else if (j - t_rise >= TIMEOUT - 1) begin
        push_stuck(j); armed = 0; t_win = j + 1;
      end else if (fall && !fell) begin
        t_fall = j; fell = 1;
      end
    end
  endtask

  task automatic step(input bit v);
    @(posedge clk);
    #1;
    cyc++;
    model_step(cyc);
    pwm_in = v;
    dly.push_front(v);
    void'(dly.pop_back());
  endtask

  task automatic drive(input bit v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #3;
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    cyc    = -1;
    model_reset();
    #1;
    check("rst_high_time", high_time, 0);
    check("rst_period", period, 0);
    check("rst_meas_valid", meas_valid, 0);
    check("rst_stuck", stuck, 0);
    check("rst_pwm_level", pwm_level, 0);
    check("rst_duty_pct", duty_pct, 0);
    check("rst_duty_valid", duty_valid, 0);
    repeat (n) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin : monitor
    meas_t e;
    duty_t d;
    if (rst_n && cyc >= 0) begin
      if (exp_meas.size() > 0 && exp_meas[0].t == cyc) begin
        e = exp_meas.pop_front();
        check("meas_valid", meas_valid, 1);
        check("high_time", high_time, e.h);
        check("period", period, e.p);
        check("stuck", stuck, e.s);
        if (e.s) check("stuck_level", pwm_level, e.lvl);
      end else if (meas_valid) begin
        check("meas_spurious", meas_valid, 0);
      end
      if (exp_duty.size() > 0 && exp_duty[0].t == cyc) begin
        d = exp_duty.pop_front();
        check("duty_valid", duty_valid, 1);
        check("duty_pct", duty_pct, d.v);
      end else if (duty_valid) begin
        check("duty_spurious", duty_valid, 0);
      end
    end
  end

  initial begin : watchdog
    #(2 * CLK_HALF * 80000);
    $display("FAIL watchdog: simulation did not finish within 80000 cycles");
    $fatal(1);
  end

  initial begin : stim
    do_reset(3);

    // 100-cycle period, 30 high
    repeat (5) begin drive(1, 30); drive(0, 70); end
    // Short periods: 1/7 then 6/7
    repeat (3) begin drive(1, 1); drive(0, 6); end
    repeat (3) begin drive(1, 6); drive(0, 1); end
    // Line stuck high after an edge
    drive(1, 1500);
    drive(0, 20);

    // Line low from reset: periodic stuck reports, then recovery
    do_reset(4);
    drive(0, 2500);
    repeat (3) begin drive(1, 50); drive(0, 50); end

    // Reset in the middle of a high phase
    drive(1, 40);
    do_reset(2);
    drive(0, 10);
    repeat (3) begin drive(1, 25); drive(0, 75); end

    // Back-to-back short periods
    repeat (8) begin drive(1, 10); drive(0, 10); end

    // Period of TIMEOUT-1 (rise beats timeout), then TIMEOUT (timeout wins)
    drive(1, 10); drive(0, TIMEOUT - 11);
    drive(1, 10); drive(0, TIMEOUT - 10);
    repeat (2) begin drive(1, 5); drive(0, 5); end

    // Randomized periods, a few near the timeout
    for (int n = 0; n < 40; n++) begin
      int p, h;
      p = (n % 8 == 7) ? int'($urandom_range(TIMEOUT + 30, TIMEOUT - 30))
                       : int'($urandom_range(60, 2));
      h = int'($urandom_range(p - 1, 1));
      drive(1, h);
      drive(0, p - h);
    end

    drive(0, 60);
    check("meas_queue_drained", exp_meas.size(), 0);
    check("duty_queue_drained", exp_duty.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
